gpio_bank: RTL and testbench

- Parametrised GPIO peripheral on the picorv32 native memory bus; next generation of the fixed 4-bit LED output port.
- Provides WIDTH bidirectional pins with per-pin direction, synchronised inputs, byte-strobed writes and edge-triggered interrupts, driving one picorv32 irq line.
- Top level decodes the peripheral window and drives mem_valid. The block decodes only mem_addr[4:2].

---
 rtl/gpio_bank_pkg.sv | 13 +
 rtl/gpio_bank_if.sv | 11 +
 rtl/gpio_sync.sv | 14 +
 rtl/gpio_bank.sv | 85 ++++++++
 tb/tb_gpio_bank.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: register indices and byte-strobe helper shared by the GPIO bank
package gpio_bank_pkg;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] OFS_OUT  = 3'd0;
  localparam logic [IDX_W-1:0] OFS_IN   = 3'd1;
  localparam logic [IDX_W-1:0] OFS_DIR  = 3'd2;
  localparam logic [IDX_W-1:0] OFS_IEN  = 3'd3;
  localparam logic [IDX_W-1:0] OFS_EDGE = 3'd4;
  localparam logic [IDX_W-1:0] OFS_PEND = 3'd5;
  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
endpackage

// File: rtl/gpio_bank_if.sv
// gpio_bank_if: picorv32 native memory bus as seen by one peripheral
interface gpio_bank_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb, input mem_ready, mem_rdata);
  modport slave  (input mem_valid, mem_addr, mem_wdata, mem_wstrb, output mem_ready, mem_rdata);
endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: per-bit flop chain bringing asynchronous pins into the clk domain
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [STAGES-1:0][WIDTH-1:0] chain_q;
  always_ff @(posedge clk) chain_q <= !resetn ? '0 : {chain_q[STAGES-2:0], d_i};
  assign q_o = chain_q[STAGES-1];
endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: WIDTH-pin GPIO with direction, byte-strobed registers and edge interrupts
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             resetn,
  gpio_bank_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d, m32;
  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, ien_q, ien_d, edge_q, edge_d;
  logic [WIDTH-1:0] pend_q, pend_d, prev_q, in_w, evt, m, wd, rd;
  logic [2:0]       cnt_q, cnt_d;
  logic             acc, wr, warm;
  logic [IDX_W-1:0] idx;
  logic             unused_ok;
  gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (gpio_i),
    .q_o    (in_w)
  );
  always_comb begin
    acc     = bus.mem_valid && !ready_q;
    wr      = acc && |bus.mem_wstrb;
    idx     = bus.mem_addr[4:2];
    m32     = strb_mask(bus.mem_wstrb);
    m       = m32[WIDTH-1:0];
    wd      = bus.mem_wdata[WIDTH-1:0];
    ready_d = acc;
    out_d   = wr && idx == OFS_OUT  ? (out_q  & ~m) | (wd & m) : out_q;
    dir_d   = wr && idx == OFS_DIR  ? (dir_q  & ~m) | (wd & m) : dir_q;
    ien_d   = wr && idx == OFS_IEN  ? (ien_q  & ~m) | (wd & m) : ien_q;
    edge_d  = wr && idx == OFS_EDGE ? (edge_q & ~m) | (wd & m) : edge_q;
    // pins high at reset would otherwise look like edges while the chain fills
    warm    = cnt_q == 3'(SYNC_STAGES + 1);
    cnt_d   = warm ? cnt_q : cnt_q + 3'd1;
    evt     = warm ? (edge_q & in_w & ~prev_q) | (~edge_q & ~in_w & prev_q) : '0;
    pend_d  = (pend_q & ~(wr && idx == OFS_PEND ? wd & m : '0)) | evt;
    rd      = idx == OFS_OUT  ? out_q  :
              idx == OFS_IN   ? in_w   :
              idx == OFS_DIR  ? dir_q  :
              idx == OFS_IEN  ? ien_q  :
              idx == OFS_EDGE ? edge_q :
              idx == OFS_PEND ? pend_q : '0;
    rdata_d = acc && !(|bus.mem_wstrb) ? 32'(rd) : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      out_q   <= OUT_RESET[WIDTH-1:0];
      dir_q   <= '0;
      ien_q   <= '0;
      edge_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      edge_q  <= edge_d;
      pend_q  <= pend_d;
      prev_q  <= in_w;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign gpio_o        = out_q;
  assign gpio_oe       = dir_q;
  assign irq           = |(pend_q & ien_q);
  assign unused_ok     = ^{bus.mem_addr[31:5], bus.mem_addr[1:0], bus.mem_wdata, m32};
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed checks of the GPIO bank at WIDTH=8 and WIDTH=5
module tb_gpio_bank;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [7:0]  gpio_i = 8'hFF;
  logic [7:0]  go8, oe8;
  logic [4:0]  go5, oe5;
  logic        irq8, irq5, rdy;
  logic [31:0] rdat;
  int          errors = 0;
  int          checks = 0;

  gpio_bank_if b8 ();
  gpio_bank_if b5 ();

  assign b8.mem_valid = valid && !sel;
  assign b5.mem_valid = valid && sel;
  assign b8.mem_addr  = addr;
  assign b5.mem_addr  = addr;
  assign b8.mem_wdata = wdata;
  assign b5.mem_wdata = wdata;
  assign b8.mem_wstrb = wstrb;
  assign b5.mem_wstrb = wstrb;
  assign rdy  = sel ? b5.mem_ready : b8.mem_ready;
  assign rdat = sel ? b5.mem_rdata : b8.mem_rdata;

  gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .OUT_RESET(32'h0)) u8 (
    .clk(clk), .resetn(resetn), .bus(b8), .gpio_i(gpio_i),
    .gpio_o(go8), .gpio_oe(oe8), .irq(irq8)
  );
  gpio_bank #(.WIDTH(5), .SYNC_STAGES(2), .OUT_RESET(32'h0)) u5 (
    .clk(clk), .resetn(resetn), .bus(b5), .gpio_i(gpio_i[4:0]),
    .gpio_o(go5), .gpio_oe(oe5), .irq(irq5)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        output logic [31:0] rd, output int lat, output bit pulse1);
    addr = a; wdata = wd; wstrb = ws; valid = 1'b1; lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!rdy && lat < 10);
    rd = rdat;
    valid = 1'b0;
    @(posedge clk); #1;
    pulse1 = !rdy;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat; bit p;
    resetn = 1'b0; gpio_i = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdy !== 1'b0 || rdat !== 32'h0) begin errors++; $display("FAIL reset_bus: ready=%b rdata=%h want 0/0", rdy, rdat); end
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq8); end
    checks++; if (oe8 !== 8'h00) begin errors++; $display("FAIL reset_oe: got %h want 00", oe8); end
    checks++; if (go8 !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", go8); end
    access(32'h14, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_pend: got %h want 0", rd); end
    access(32'h04, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h000000FF) begin errors++; $display("FAIL reset_in: got %h want 000000ff", rd); end
  endtask

  task automatic test_warmup();
    logic [31:0] rd; int lat; bit p;
    resetn = 1'b0; gpio_i = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    access(32'h10, 32'hFF, 4'h1, rd, lat, p);
    repeat (4) @(posedge clk);
    #1;
    access(32'h14, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL warmup_pend: got %h want 0", rd); end
    access(32'h10, 32'h0, 4'h1, rd, lat, p);
  endtask

  task automatic test_out_dir();
    logic [31:0] rd; int lat; bit p;
    access(32'h08, 32'h0F, 4'hF, rd, lat, p);
    checks++; if (lat !== 1 || !p) begin errors++; $display("FAIL dir_handshake: lat=%0d pulse=%b want 1/1", lat, p); end
    access(32'h00, 32'hA5A5A5A5, 4'b0001, rd, lat, p);
    checks++; if (lat !== 1 || !p) begin errors++; $display("FAIL out_handshake: lat=%0d pulse=%b want 1/1", lat, p); end
    checks++; if (oe8 !== 8'h0F) begin errors++; $display("FAIL gpio_oe: got %h want 0f", oe8); end
    checks++; if (go8 !== 8'hA5) begin errors++; $display("FAIL gpio_o: got %h want a5", go8); end
    access(32'h00, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h000000A5 || lat !== 1) begin errors++; $display("FAIL out_read: got %h lat=%0d want 000000a5 lat=1", rd, lat); end
    access(32'h00, 32'hFFFFFF00, 4'b1110, rd, lat, p);
    checks++; if (go8 !== 8'hA5) begin errors++; $display("FAIL out_strobe: got %h want a5", go8); end
  endtask

  task automatic test_edge();
    logic [31:0] rd; int lat, n; bit p;
    access(32'h10, 32'h01, 4'h1, rd, lat, p);
    access(32'h0C, 32'h01, 4'h1, rd, lat, p);
    gpio_i = 8'hFE;
    repeat (5) @(posedge clk);
    #1;
    access(32'h14, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_ignored_fall: got %h want 0", rd); end
    gpio_i = 8'hFF;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!irq8 && n < 10);
    checks++; if (n !== 3 || irq8 !== 1'b1) begin errors++; $display("FAIL edge_latency: cycles=%0d irq=%b want 3/1", n, irq8); end
    gpio_i = 8'hFD;
    repeat (5) @(posedge clk);
    #1;
    access(32'h14, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h03) begin errors++; $display("FAIL edge_fall_bit1: got %h want 03", rd); end
    checks++; if (irq8 !== 1'b1) begin errors++; $display("FAIL edge_irq: got %b want 1", irq8); end
  endtask

  task automatic test_w1c();
    logic [31:0] rd; int lat; bit p;
    gpio_i = 8'hFC;
    repeat (5) @(posedge clk);
    #1;
    gpio_i = 8'hFD;
    repeat (2) @(posedge clk);
    #1;
    access(32'h14, 32'h01, 4'h1, rd, lat, p);
    access(32'h14, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h03) begin errors++; $display("FAIL w1c_set_wins: got %h want 03", rd); end
    access(32'h14, 32'hFF, 4'b0010, rd, lat, p);
    access(32'h14, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h03) begin errors++; $display("FAIL w1c_strobe: got %h want 03", rd); end
    access(32'h14, 32'h01, 4'h1, rd, lat, p);
    checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b want 0", irq8); end
    access(32'h14, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h02) begin errors++; $display("FAIL w1c_clear: got %h want 02", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat; bit p;
    addr = 32'h04; wdata = '0; wstrb = 4'h0; valid = 1'b1; resetn = 1'b0;
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b0 || rdat !== 32'h0) begin errors++; $display("FAIL midreset_bus: ready=%b rdata=%h want 0/0", rdy, rdat); end
    checks++; if (oe8 !== 8'h00 || go8 !== 8'h00 || irq8 !== 1'b0) begin errors++; $display("FAIL midreset_regs: oe=%h out=%h irq=%b want 00/00/0", oe8, go8, irq8); end
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b1 || rdat !== 32'h0) begin errors++; $display("FAIL midreset_resume: ready=%b rdata=%h want 1/0", rdy, rdat); end
    valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL midreset_pulse: ready=%b want 0", rdy); end
    access(32'h10, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midreset_edge: got %h want 0", rd); end
    access(32'h0C, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midreset_ien: got %h want 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    logic [31:0] rd; int lat; bit p;
    access(32'h00, 32'h3C, 4'h1, rd, lat, p);
    addr = 32'h00; wstrb = 4'h0; valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[i] = rdy;
    end
    valid = 1'b0;
    checks++; if (pat !== 4'b0101 || rdat !== 32'h3C) begin errors++; $display("FAIL back_to_back: ready=%b rdata=%h want 0101/3c", pat, rdat); end
    @(posedge clk); #1;
  endtask

  task automatic test_reserved();
    logic [31:0] rd; int lat; bit p;
    gpio_i = 8'h3C;
    access(32'h00, 32'h5A, 4'h1, rd, lat, p);
    access(32'h18, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h0 || lat !== 1 || !p) begin errors++; $display("FAIL rsv_read: got %h lat=%0d pulse=%b want 0/1/1", rd, lat, p); end
    access(32'h1C, 32'hFFFFFFFF, 4'hF, rd, lat, p);
    checks++; if (lat !== 1 || !p) begin errors++; $display("FAIL rsv_write: lat=%0d pulse=%b want 1/1", lat, p); end
    access(32'h04, 32'hFFFFFFFF, 4'hF, rd, lat, p);
    access(32'h00, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h5A) begin errors++; $display("FAIL rsv_out: got %h want 5a", rd); end
    access(32'h08, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rsv_dir: got %h want 0", rd); end
    access(32'h04, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h3C) begin errors++; $display("FAIL in_readonly: got %h want 3c", rd); end
  endtask

  task automatic test_width5();
    logic [31:0] rd; int lat; bit p;
    sel = 1'b1;
    access(32'h00, 32'hFF, 4'hF, rd, lat, p);
    access(32'h00, 0, 4'h0, rd, lat, p);
    checks++; if (rd !== 32'h1F) begin errors++; $display("FAIL w5_read: got %h want 1f", rd); end
    checks++; if (go5 !== 5'h1F) begin errors++; $display("FAIL w5_pins: got %h want 1f", go5); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_out_dir();
    test_edge();
    test_w1c();
    test_reset_mid();
    test_back_to_back();
    test_reserved();
    test_width5();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
